sw_load_display: RTL and testbench
==================================

Name: sw_load_display

Overview:
- Parametrised successor to the switch-load / two-digit HEX display path.
- A debounced active-low key captures the switch bank into a value register. In accumulate mode the switch value is added to the register instead.
- A sequential binary-to-BCD converter (shift-add-3) feeds NUM_DIGITS active-low seven-segment outputs, with optional leading-zero blanking and an overflow indication.
- Sits between board pins (SW, KEY, HEX) and the rest of the design. It also exports the held value for a processor PIO.

Parameters:
SW_WIDTH, 4, width of switch input bank
VAL_WIDTH, 8, width of value register (must be >= SW_WIDTH)
NUM_DIGITS, 3, number of seven-segment digits driven (1..6)
ACCUM_MODE, 0, 0 = press loads switch value; 1 = press adds switch value modulo 2^VAL_WIDTH
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key change (20 ms at 50 MHz)

Ports:
CLOCK_50  input  1  system clock; the single clock for the block
reset  input  1  asynchronous, active-high reset
sw_in  input  SW_WIDTH  raw switch bank, sampled on an accepted press
key_load_n  input  1  raw active-low load/add key, asynchronous to CLOCK_50
key_clr_n  input  1  raw active-low clear key, debounced identically to key_load_n
hex_out  output  7*NUM_DIGITS  segments; digit k occupies bits [7k+6:7k]; bit 0 = a ... bit 6 = g; active-low
value_out  output  VAL_WIDTH  current value register
busy  output  1  high while a BCD conversion is in progress
load_pulse  output  1  one-cycle pulse when value register is updated by load, add or clear

Behaviour:
- Reset state (asynchronous assert, synchronous release):
  - value_out = 0, busy = 0, load_pulse = 0, FSM in IDLE, debouncers stable-high.
  - hex_out: digit 0 = 7'b1000000 ("0"); other digits = 7'b1111111 if BLANK_LZ, else 7'b1000000.
- Synchroniser: each key passes through a 2-FF synchroniser, then a debouncer.
- Debouncer:
  - Counter increments while the synced level differs from the stable level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - Press event = stable 1->0 transition, one cycle wide. Release generates nothing.
- Value update, registered in the cycle after the press event:
  - Load press: value <= zero-extended sw_in (ACCUM_MODE=0), or value + sw_in with wrap at 2^VAL_WIDTH (ACCUM_MODE=1).
  - Clear press: value <= 0.
  - Same-cycle load and clear: clear wins.
  - load_pulse is high in the same cycle value_out changes.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on load_pulse: capture value into a shift register, zero the BCD register, set busy.
  - SHIFT runs exactly VAL_WIDTH cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift left one bit. BCD width is 4*NUM_DIGITS plus an overflow guard.
  - SHIFT -> DONE after the last shift.
  - DONE (1 cycle): register hex_out from BCD, clear busy, return to IDLE.
- Latency: hex_out reflects the new value exactly VAL_WIDTH+2 cycles after the load_pulse cycle. hex_out holds its old contents until then.
- Restart: load_pulse during SHIFT or DONE restarts SHIFT from the new value. The old result is discarded and hex_out is not updated with it. busy stays high.
- Overflow: if value >= 10^NUM_DIGITS (any BCD bit above the displayed digits is set), every digit shows "-" (7'b0111111).
- Segment encoding for 0..9: 40,79,24,30,19,12,02,78,00,10 (hex, active-low).
- Blanking (BLANK_LZ=1): digits above the most significant non-zero digit show 7'b1111111. Digit 0 always shows a numeral.
- Debounce under reset: a reset mid-bounce clears the debounce counter and stable level. A key held low through reset release therefore produces one press once debounced.

Test Plan (DEBOUNCE_CYCLES=4, VAL_WIDTH=8, NUM_DIGITS=3):
1. Reset checks: assert reset -> value_out=0, busy=0, hex_out={7F,7F,40} (digit2..0).
2. Debounced load: sw_in=9, key_load_n low for 10 cycles -> exactly one load_pulse; value_out=9; 10 cycles later busy=0 and hex_out digit0=10, digits 1..2 blank.
3. Glitch rejection: key_load_n low for 3 cycles then high -> no load_pulse, value unchanged.
4. Accumulate wrap (ACCUM_MODE=1): from 250, press with sw_in=15 -> value_out=9 (265 mod 256); display shows 9.
5. Overflow and display (NUM_DIGITS=2): value 123 -> hex_out={3F,3F}. Value 99 -> {10,10}.
6. Restart and priority: second load press during SHIFT -> busy stays high, hex_out updates only with the second value. Simultaneous load and clear -> value_out=0, display "0".

Source files
------------

// File: rtl/sw_load_display.sv
// Switch-load register with debounced keys, sequential binary-to-BCD conversion
// and an active-low seven-segment display path with blanking and overflow dashes.
module sw_load_display #(
  parameter int SW_WIDTH        = 4,
  parameter int VAL_WIDTH       = 8,
  parameter int NUM_DIGITS      = 3,
  parameter int ACCUM_MODE      = 0,
  parameter int BLANK_LZ        = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [SW_WIDTH-1:0]       sw_in,
  input  logic                      key_load_n,
  input  logic                      key_clr_n,
  output logic [7*NUM_DIGITS-1:0]   hex_out,
  output logic [VAL_WIDTH-1:0]      value_out,
  output logic                      busy,
  output logic                      load_pulse
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int BCD_D  = 4 * NUM_DIGITS;
  localparam int BCD_W  = BCD_D + 1;
  localparam int SCNT_W = $clog2(VAL_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SHFT_MAX = SCNT_W'(VAL_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // Index 0 is the load key, index 1 the clear key.
  logic [1:0]            w_keys_n;
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_stable;
  logic [1:0]            r_press;
  logic [1:0][CNT_W-1:0] r_cnt;

  logic [VAL_WIDTH-1:0]  w_sw_ext;
  logic [VAL_WIDTH-1:0]  r_value;
  logic                  r_load_pulse;

  state_t                r_state;
  logic [SCNT_W-1:0]     r_bcnt;
  logic                  r_busy;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [VAL_WIDTH-1:0]  r_shift;
  logic [BCD_W-1:0]      r_bcd;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // One shift-add-3 step; the top bit is a sticky flag for carries out of the
  // most significant displayed digit.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                input logic in_bit);
    logic [BCD_D-1:0] adj;
    adj = bcd[BCD_D-1:0];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    return {bcd[BCD_W-1] | adj[BCD_D-1], adj[BCD_D-2:0], in_bit};
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] render(input logic [BCD_W-1:0] bcd);
    logic [7*NUM_DIGITS-1:0] segs;
    logic                    lead;
    segs = '0;
    lead = (BLANK_LZ != 0);
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (bcd[4*k +: 4] != 4'd0) lead = 1'b0;
      if (bcd[BCD_W-1])
        segs[7*k +: 7] = 7'h3F;
      else if (lead && k != 0)
        segs[7*k +: 7] = 7'h7F;
      else
        segs[7*k +: 7] = seg7(bcd[4*k +: 4]);
    end
    return segs;
  endfunction

  assign w_keys_n = {key_clr_n, key_load_n};
  assign w_sw_ext = VAL_WIDTH'(sw_in);

  // Stage: key synchronisers and debouncers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_press  <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= w_keys_n;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
          r_press[i]  <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage: value register update, clear has priority over load
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_value      <= '0;
      r_load_pulse <= 1'b0;
    end else begin
      r_load_pulse <= |r_press;
      if (r_press[1]) begin
        r_value <= '0;
      end else if (r_press[0]) begin
        if (ACCUM_MODE != 0) r_value <= r_value + w_sw_ext;
        else                 r_value <= w_sw_ext;
      end
    end
  end

  // Stage: conversion control; a new value restarts from any state
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_busy  <= 1'b0;
      r_hex   <= render('0);
    end else if (r_load_pulse) begin
      r_state <= S_SHIFT;
      r_bcnt  <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_bcnt <= r_bcnt + 1'b1;
          if (r_bcnt == SHFT_MAX) r_state <= S_DONE;
        end
        S_DONE: begin
          r_hex   <= render(r_bcd);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage: conversion datapath
  always_ff @(posedge CLOCK_50) begin
    if (r_load_pulse) begin
      r_shift <= r_value;
      r_bcd   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_bcd   <= bcd_step(r_bcd, r_shift[VAL_WIDTH-1]);
      r_shift <= r_shift << 1;
    end
  end

  assign hex_out    = r_hex;
  assign value_out  = r_value;
  assign busy       = r_busy;
  assign load_pulse = r_load_pulse;

endmodule

// File: tb/tb_sw_load_display.sv
// Bench for sw_load_display: one load-mode and two accumulate-mode instances
// share the same keys; a queue holds the values expected at each load_pulse.
module tb_sw_load_display;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic        kl_n, kc_n;
  logic [20:0] hex0, hex1;
  logic [13:0] hex2;
  logic [7:0]  v0, v1, v2;
  logic        b0, b1, b2, p0, p1, p2;

  sw_load_display #(.SW_WIDTH(4), .VAL_WIDTH(8), .NUM_DIGITS(3), .ACCUM_MODE(0),
                    .BLANK_LZ(1), .DEBOUNCE_CYCLES(DB)) u0 (
    .CLOCK_50(clk), .reset(rst), .sw_in(sw), .key_load_n(kl_n), .key_clr_n(kc_n),
    .hex_out(hex0), .value_out(v0), .busy(b0), .load_pulse(p0));

  sw_load_display #(.SW_WIDTH(4), .VAL_WIDTH(8), .NUM_DIGITS(3), .ACCUM_MODE(1),
                    .BLANK_LZ(1), .DEBOUNCE_CYCLES(DB)) u1 (
    .CLOCK_50(clk), .reset(rst), .sw_in(sw), .key_load_n(kl_n), .key_clr_n(kc_n),
    .hex_out(hex1), .value_out(v1), .busy(b1), .load_pulse(p1));

  sw_load_display #(.SW_WIDTH(4), .VAL_WIDTH(8), .NUM_DIGITS(2), .ACCUM_MODE(1),
                    .BLANK_LZ(1), .DEBOUNCE_CYCLES(DB)) u2 (
    .CLOCK_50(clk), .reset(rst), .sw_in(sw), .key_load_n(kl_n), .key_clr_n(kc_n),
    .hex_out(hex2), .value_out(v2), .busy(b2), .load_pulse(p2));

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] v0;
    logic [7:0] va;
  } exp_t;

  typedef struct {
    bit         ld;
    bit         clr;
    logic [3:0] sw;
    int         hold;
    bit         pulse;
    logic [7:0] exp_v;
    logic [7:0] exp_a;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  // Decimal reference display built with division, digit 0 in the low bits.
  function automatic logic [41:0] model_hex(input int v, input int nd);
    logic [41:0] r;
    int lim, p;
    r = '0;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (v >= lim)          r[7*k +: 7] = 7'h3F;
      else if (k > 0 && v < p) r[7*k +: 7] = 7'h7F;
      else                   r[7*k +: 7] = seg_of((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] ev, input logic [7:0] ea);
    exp_t e;
    e.v0 = ev;
    e.va = ea;
    sb.push_back(e);
  endtask

  task automatic add_vec(input bit ld, input bit clr, input logic [3:0] s, input int hold,
                         input bit pulse, input logic [7:0] ev, input logic [7:0] ea);
    vec_t t;
    t.ld = ld; t.clr = clr; t.sw = s; t.hold = hold;
    t.pulse = pulse; t.exp_v = ev; t.exp_a = ea;
    vecs.push_back(t);
  endtask

  task automatic check_display(input string tag, input int ev, input int ea);
    logic [41:0] h;
    h = model_hex(ev, 3);
    chk({tag, "_hex_load3"}, hex0, h[20:0]);
    h = model_hex(ea, 3);
    chk({tag, "_hex_acc3"}, hex1, h[20:0]);
    h = model_hex(ea, 2);
    chk({tag, "_hex_acc2"}, hex2, h[13:0]);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((b0 || b1 || b2) && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("busy_idle", {b0, b1, b2}, 3'b000);
  endtask

  task automatic apply(input vec_t t);
    if (t.pulse) push_exp(t.exp_v, t.exp_a);
    sw   = t.sw;
    kl_n = !t.ld;
    kc_n = !t.clr;
    repeat (t.hold) @(negedge clk);
    kl_n = 1'b1;
    kc_n = 1'b1;
    repeat (12) @(negedge clk);
    wait_idle();
    chk("pulse_count", sb.size(), 0);
    sb.delete();
    chk("value_load3", v0, t.exp_v);
    chk("value_acc3", v1, t.exp_a);
    chk("value_acc2", v2, t.exp_a);
    check_display("vec", int'(t.exp_v), int'(t.exp_a));
  endtask

  // Scoreboard: every load_pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && p0) begin
      chk("pulse_expected", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pulse_value_load3", v0, e.v0);
        chk("pulse_value_acc3", v1, e.va);
        chk("pulse_value_acc2", v2, e.va);
        chk("pulse_aligned", {p1, p2}, 2'b11);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seq[$];
    int acc;
    int tc;
    int busy_cnt;
    logic [41:0] h;

    add_vec(1, 0,  9, 10, 1,  9,  9);
    add_vec(1, 0,  5,  3, 0,  9,  9);
    add_vec(1, 0,  7, 10, 1,  7, 16);
    add_vec(0, 1,  0, 10, 1,  0,  0);
    add_vec(1, 0, 15, 10, 1, 15, 15);
    add_vec(1, 1,  3, 10, 1,  0,  0);
    seq = '{15, 15, 15, 15, 15, 15, 9, 15, 9,
            15, 15, 15, 15, 15, 15, 15, 15, 7, 15};
    acc = 0;
    foreach (seq[i]) begin
      acc = (acc + seq[i]) % 256;
      add_vec(1, 0, 4'(seq[i]), 10, 1, 8'(seq[i]), 8'(acc));
    end

    rst  = 1'b1;
    sw   = 4'd0;
    kl_n = 1'b1;
    kc_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_value", v0, 0);
    chk("rst_busy", {b0, b1, b2}, 3'b000);
    chk("rst_pulse", {p0, p1, p2}, 3'b000);
    chk("rst_hex3", hex0, {7'h7F, 7'h7F, 7'h40});
    chk("rst_hex2", hex2, {7'h7F, 7'h40});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Clear lands four cycles after the load, inside the conversion.
    push_exp(8'd13, 8'd22);
    push_exp(8'd0, 8'd0);
    sw = 4'd13;
    tc = -1;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tc < 0 && p0) tc = c;
      if (tc >= 0 && c >= tc + 1 && c <= tc + 13 && b0) busy_cnt++;
      if (tc >= 0 && c == tc + 10) begin
        h = model_hex(15, 3);
        chk("restart_hex_held", hex0, h[20:0]);
      end
      if (tc >= 0 && c == tc + 14) begin
        h = model_hex(0, 3);
        chk("restart_hex_new", hex0, h[20:0]);
        chk("restart_busy_low", b0, 0);
      end
      kl_n = !(c < 10);
      kc_n = !(c >= 4 && c < 14);
    end
    chk("restart_pulse_seen", 64'(tc >= 0), 1);
    chk("restart_busy_held", busy_cnt, 13);
    wait_idle();
    chk("restart_pulses", sb.size(), 0);
    sb.delete();
    check_display("restart", 0, 0);

    // Reset in the middle of a bounce; the key stays low through release.
    sw   = 4'd5;
    kl_n = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_value", v1, 0);
    chk("midrst_busy", {b0, b1, b2}, 3'b000);
    chk("midrst_hex3", hex1, {7'h7F, 7'h7F, 7'h40});
    push_exp(8'd5, 8'd5);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    kl_n = 1'b1;
    repeat (12) @(negedge clk);
    wait_idle();
    chk("midrst_pulses", sb.size(), 0);
    sb.delete();
    check_display("midrst", 5, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
